// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - PWM duty ramp/soft-start/soft-stop sequencer with fault shutdown
module pwm_duty_sequencer #(
    parameter int DUTY_W    = 4,
    parameter int DUTY_MAX  = 10,
    parameter int DUTY_INIT = 5,
    parameter int RATE_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              inc_pulse,
    input  logic              dec_pulse,
    input  logic              tgt_load,
    input  logic [DUTY_W-1:0] tgt_in,
    input  logic [RATE_W-1:0] rate,
    input  logic              period_end,
    input  logic              fault,
    output logic [DUTY_W-1:0] duty_out,
    output logic [DUTY_W-1:0] target,
    output logic              busy,
    output logic              fault_latched
);

    localparam logic [DUTY_W-1:0] DMAX  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DINIT = DUTY_W'(DUTY_INIT);

    typedef enum logic [2:0] {
        S_OFF,
        S_RAMP,
        S_HOLD,
        S_STOP,
        S_FAULT
    } state_t;

    state_t            state, next_state;
    logic [RATE_W-1:0] step_cnt;
    logic [RATE_W:0]   rate_eff;
    logic [RATE_W:0]   cnt_inc;
    logic              step_hit;
    logic              stepping;
    logic              step_en;
    logic [DUTY_W-1:0] goal;
    logic [DUTY_W-1:0] duty_next;
    logic [DUTY_W-1:0] target_next;

    always_comb begin
        rate_eff = (rate == '0) ? (RATE_W+1)'(1) : {1'b0, rate};
        cnt_inc  = {1'b0, step_cnt} + (RATE_W+1)'(1);
        step_hit = (cnt_inc >= rate_eff);
        stepping = (state == S_RAMP) || (state == S_STOP);
    end

    // en changes outrank target changes; fault outranks both.
    always_comb begin
        next_state = state;
        if (state != S_FAULT && fault) begin
            next_state = S_FAULT;
        end else begin
            unique case (state)
                S_OFF:   if (en) next_state = S_RAMP;
                S_RAMP: begin
                    if (!en)                    next_state = S_STOP;
                    else if (duty_out == target) next_state = S_HOLD;
                end
                S_HOLD: begin
                    if (!en)                    next_state = S_STOP;
                    else if (duty_out != target) next_state = S_RAMP;
                end
                S_STOP: begin
                    if (en)                     next_state = S_RAMP;
                    else if (duty_out == '0)    next_state = S_OFF;
                end
                S_FAULT: if (!fault && !en) next_state = S_OFF;
                default: next_state = S_OFF;
            endcase
        end
    end

    // A step is only taken when the state is not changing this cycle.
    always_comb begin
        step_en = period_end && stepping && step_hit && (next_state == state);
        goal    = (state == S_STOP) ? '0 : target;
        if (duty_out < goal)
            duty_next = duty_out + DUTY_W'(1);
        else if (duty_out > goal)
            duty_next = duty_out - DUTY_W'(1);
        else
            duty_next = duty_out;
    end

    always_comb begin
        target_next = target;
        if (state != S_FAULT) begin
            if (tgt_load)
                target_next = (tgt_in > DMAX) ? DMAX : tgt_in;
            else if (inc_pulse && !dec_pulse && target < DMAX)
                target_next = target + DUTY_W'(1);
            else if (dec_pulse && !inc_pulse && target != '0)
                target_next = target - DUTY_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_OFF;
            duty_out      <= '0;
            target        <= DINIT;
            step_cnt      <= '0;
            busy          <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state         <= next_state;
            target        <= target_next;
            busy          <= (next_state == S_RAMP) || (next_state == S_STOP);
            fault_latched <= (next_state == S_FAULT);

            if (next_state != state)
                step_cnt <= '0;
            else if (stepping && period_end)
                step_cnt <= step_hit ? '0 : cnt_inc[RATE_W-1:0];

            if (next_state == S_FAULT)
                duty_out <= '0;
            else if (step_en)
                duty_out <= duty_next;
        end
    end

endmodule
